// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO read port into a valid/ready stream through a 2-entry skid buffer.
// Optional beat counter output xfer_count is built when FIFO_RD_STATS_EN is defined.
module fifo_stream_reader #(
   parameter int FIFO_WIDTH = 16,
   parameter int SKID_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fifo_empty,
   input  logic [FIFO_WIDTH-1:0] fifo_dout,
   input  logic                  fifo_underflow,
   output logic                  fifo_rd_en,
   output logic                  m_valid,
   output logic [FIFO_WIDTH-1:0] m_data,
   input  logic                  m_ready,
   output logic                  rd_err
`ifdef FIFO_RD_STATS_EN
   ,
   output logic [31:0]           xfer_count
`endif
);

   generate
      if (SKID_DEPTH != 2) begin : g_depth_chk
         $error("fifo_stream_reader: SKID_DEPTH must be 2");
      end
   endgenerate

   logic [1:0]            occ;
   logic                  inflight;
   logic                  head_ptr;
   logic                  tail_ptr;
   logic [FIFO_WIDTH-1:0] skid_mem [2];
   logic                  pop;
   logic [2:0]            fill;

   // Read issue: count the word in flight so the buffer can never be overcommitted.
   assign pop        = m_valid && m_ready;
   assign fill       = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
   assign fifo_rd_en = rst_n && !fifo_empty && (fill < 3'd2);

   assign m_valid = (occ != 2'd0);
   assign m_data  = skid_mem[head_ptr];

   // Capture stage: FIFO data lands one cycle after the accepted read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ         <= 2'd0;
         inflight    <= 1'b0;
         head_ptr    <= 1'b0;
         tail_ptr    <= 1'b0;
         rd_err      <= 1'b0;
         skid_mem[0] <= '0;
         skid_mem[1] <= '0;
      end else begin
         inflight <= fifo_rd_en;
         occ      <= fill[1:0];
         if (inflight) begin
            skid_mem[tail_ptr] <= fifo_dout;
            tail_ptr           <= ~tail_ptr;
         end
         if (pop) begin
            head_ptr <= ~head_ptr;
         end
         if (inflight && fifo_underflow) begin
            rd_err <= 1'b1;
         end
      end
   end

`ifdef FIFO_RD_STATS_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   logic [31:0] xfer_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xfer_cnt <= 32'd0;
      end else if (pop) begin
         xfer_cnt <= sat_inc(xfer_cnt);
      end
   end

   assign xfer_count = xfer_cnt;
`endif

endmodule
